// File: rtl/emotion_pkg.sv
// Shared types and the combinational emotion decode used by the emotion tracker.
package emotion_pkg;

    typedef enum logic [1:0] {
        LVL_LOW  = 2'b00,
        LVL_OK   = 2'b01,
        LVL_HIGH = 2'b10
    } level_e;

    typedef enum logic [1:0] {
        ST_SLEEP   = 2'b00,
        ST_STABLE  = 2'b01,
        ST_PENDING = 2'b10
    } state_e;

    localparam int unsigned EMO_TENSE    = 7;
    localparam int unsigned EMO_AGITATED = 6;
    localparam int unsigned EMO_UNHAPPY  = 5;
    localparam int unsigned EMO_TIRED    = 4;
    localparam int unsigned EMO_DRIFTING = 3;
    localparam int unsigned EMO_EXCITED  = 2;
    localparam int unsigned EMO_CONTENT  = 1;
    localparam int unsigned EMO_HAPPY    = 0;

    function automatic logic [7:0] decode_emotion(
        input level_e e,
        input level_e s,
        input level_e p,
        input logic   awake
    );
        logic       e_h, e_o, e_l;
        logic       s_h, s_o, s_l;
        logic       p_h, p_o, p_l;
        logic [7:0] v;
        e_h = (e == LVL_HIGH);
        e_o = (e == LVL_OK);
        e_l = (e == LVL_LOW);
        s_h = (s == LVL_HIGH);
        s_o = (s == LVL_OK);
        s_l = (s == LVL_LOW);
        p_h = (p == LVL_HIGH);
        p_o = (p == LVL_OK);
        p_l = (p == LVL_LOW);
        v = 8'h00;
        v[EMO_TENSE]    = (p_h & s_h & e_h) | (p_o & s_h);
        v[EMO_AGITATED] = ~p_h & s_o & e_h;
        v[EMO_UNHAPPY]  = p_l & s_h;
        v[EMO_TIRED]    = ~s_h & e_l;
        v[EMO_DRIFTING] = (p_l & s_l & e_h) | (p_l & ~s_h & e_o);
        v[EMO_EXCITED]  = (p_h & ~s_h & e_h) | (p_h & s_h & ~e_h) | (p_o & s_l & e_h);
        v[EMO_CONTENT]  = p_o & ~s_h & e_o;
        v[EMO_HAPPY]    = p_h & ~s_h & e_o;
        return v & {8{awake}};
    endfunction

endpackage

// File: rtl/emotion_quantizer.sv
// Three-way level quantiser: below LOW_TH is LOW, at or above HIGH_TH is HIGH, else OK.
module emotion_quantizer
    import emotion_pkg::*;
#(
    parameter int LEVEL_W = 4,
    parameter int LOW_TH  = 4,
    parameter int HIGH_TH = 12
) (
    input  logic [LEVEL_W-1:0] level,
    output logic [1:0]         code
);

    localparam logic [LEVEL_W-1:0] LOW_TH_L  = LOW_TH[LEVEL_W-1:0];
    localparam logic [LEVEL_W-1:0] HIGH_TH_L = HIGH_TH[LEVEL_W-1:0];

    // Threshold compare into the two-bit level code
    always_comb begin
        code = LVL_OK;
        if (level < LOW_TH_L) begin
            code = LVL_LOW;
        end else if (level >= HIGH_TH_L) begin
            code = LVL_HIGH;
        end else begin
            code = LVL_OK;
        end
    end

endmodule

// File: rtl/emotion_tracker.sv
// Samples quantised levels, decodes a candidate emotion and commits it after a
// debounce of HOLD_CYCLES matching samples; an asleep sample forces neutral.
module emotion_tracker
    import emotion_pkg::*;
#(
    parameter int LEVEL_W     = 4,
    parameter int LOW_TH      = 4,
    parameter int HIGH_TH     = 12,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [LEVEL_W-1:0] energy,
    input  logic [LEVEL_W-1:0] stress,
    input  logic [LEVEL_W-1:0] pleasure,
    input  logic [1:0]         physical_state,
    output logic [7:0]         emotion,
    output logic               emotion_changed,
    output logic               pending,
    output logic               sleeping
);

    localparam int              CNT_W  = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_L = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [1:0] e_code_s, s_code_s, p_code_s;

    emotion_quantizer #(.LEVEL_W(LEVEL_W), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH)) u_q_energy (
        .level (energy),
        .code  (e_code_s)
    );
    emotion_quantizer #(.LEVEL_W(LEVEL_W), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH)) u_q_stress (
        .level (stress),
        .code  (s_code_s)
    );
    emotion_quantizer #(.LEVEL_W(LEVEL_W), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH)) u_q_pleasure (
        .level (pleasure),
        .code  (p_code_s)
    );

    level_e e_q_r, s_q_r, p_q_r;
    logic   awake_r;
    logic   s1_valid_r;

    // Stage 1: capture the quantised triple and awake flag on each valid sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q_r      <= LVL_LOW;
            s_q_r      <= LVL_LOW;
            p_q_r      <= LVL_LOW;
            awake_r    <= 1'b0;
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                e_q_r   <= level_e'(e_code_s);
                s_q_r   <= level_e'(s_code_s);
                p_q_r   <= level_e'(p_code_s);
                awake_r <= (physical_state == 2'b00);
            end
        end
    end

    logic [7:0]       cand_s;
    state_e           state_r, state_nxt_s;
    logic [7:0]       emotion_r, emotion_nxt_s;
    logic [7:0]       pend_r, pend_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
    logic             changed_r, changed_nxt_s;
    logic             pending_r, pending_nxt_s;
    logic             sleeping_r, sleeping_nxt_s;

    assign cand_s    = decode_emotion(e_q_r, s_q_r, p_q_r, awake_r);
    assign cnt_inc_s = cnt_r + CNT_ONE;

    // State register plus registered outputs, updated from next-state values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_SLEEP;
            emotion_r  <= 8'h00;
            pend_r     <= 8'h00;
            cnt_r      <= CNT_ZERO;
            changed_r  <= 1'b0;
            pending_r  <= 1'b0;
            sleeping_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            emotion_r  <= emotion_nxt_s;
            pend_r     <= pend_nxt_s;
            cnt_r      <= cnt_nxt_s;
            changed_r  <= changed_nxt_s;
            pending_r  <= pending_nxt_s;
            sleeping_r <= sleeping_nxt_s;
        end
    end

    // Next-state logic; without a stage-1 sample everything holds
    always_comb begin
        state_nxt_s   = state_r;
        emotion_nxt_s = emotion_r;
        pend_nxt_s    = pend_r;
        cnt_nxt_s     = cnt_r;
        changed_nxt_s = 1'b0;
        if (!s1_valid_r) begin
            changed_nxt_s = 1'b0;
        end else if (!awake_r) begin
            state_nxt_s   = ST_SLEEP;
            emotion_nxt_s = 8'h00;
            cnt_nxt_s     = CNT_ZERO;
            changed_nxt_s = (emotion_r != 8'h00);
        end else begin
            case (state_r)
                // Waking commits immediately so the display never lags a wake-up
                ST_SLEEP: begin
                    state_nxt_s   = ST_STABLE;
                    emotion_nxt_s = cand_s;
                    cnt_nxt_s     = CNT_ZERO;
                    changed_nxt_s = (cand_s != 8'h00);
                end
                ST_STABLE: begin
                    if (cand_s != emotion_r) begin
                        state_nxt_s = ST_PENDING;
                        pend_nxt_s  = cand_s;
                        cnt_nxt_s   = CNT_ONE;
                    end else begin
                        state_nxt_s = ST_STABLE;
                    end
                end
                ST_PENDING: begin
                    if (cand_s == emotion_r) begin
                        state_nxt_s = ST_STABLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cand_s == pend_r) begin
                        if (cnt_inc_s == HOLD_L) begin
                            state_nxt_s   = ST_STABLE;
                            emotion_nxt_s = pend_r;
                            cnt_nxt_s     = CNT_ZERO;
                            changed_nxt_s = 1'b1;
                        end else begin
                            cnt_nxt_s = cnt_inc_s;
                        end
                    end else begin
                        pend_nxt_s = cand_s;
                        cnt_nxt_s  = CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s   = ST_SLEEP;
                    emotion_nxt_s = 8'h00;
                    cnt_nxt_s     = CNT_ZERO;
                end
            endcase
        end
    end

    // Status flags derived from the next state so they register alongside it
    always_comb begin
        pending_nxt_s  = (state_nxt_s == ST_PENDING);
        sleeping_nxt_s = (state_nxt_s == ST_SLEEP);
    end

    assign emotion         = emotion_r;
    assign emotion_changed = changed_r;
    assign pending         = pending_r;
    assign sleeping        = sleeping_r;

endmodule

// File: tb/tb_emotion_tracker.sv
// Directed self-checking bench for emotion_tracker with hand-computed expectations.
module tb_emotion_tracker;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] energy, stress, pleasure;
    logic [1:0] physical_state;
    logic [7:0] emotion;
    logic       emotion_changed, pending, sleeping;

    int tests_run    = 0;
    int tests_failed = 0;

    emotion_tracker #(
        .LEVEL_W(4), .LOW_TH(4), .HIGH_TH(12), .HOLD_CYCLES(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .energy          (energy),
        .stress          (stress),
        .pleasure        (pleasure),
        .physical_state  (physical_state),
        .emotion         (emotion),
        .emotion_changed (emotion_changed),
        .pending         (pending),
        .sleeping        (sleeping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives one sample for one cycle, returns at the next negedge
    task automatic put(input logic [3:0] e, input logic [3:0] s, input logic [3:0] p,
                       input logic [1:0] ps);
        energy         = e;
        stress         = s;
        pleasure       = p;
        physical_state = ps;
        in_valid       = 1'b1;
        @(negedge clk);
        in_valid       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0;
        energy = 4'd0; stress = 4'd0; pleasure = 4'd0; physical_state = 2'b00;
        idle(2);
        check_eq("rst_emotion",  emotion, 8'h00);
        check_eq("rst_sleeping", {7'd0, sleeping}, 8'h01);
        check_eq("rst_pending",  {7'd0, pending}, 8'h00);
        check_eq("rst_changed",  {7'd0, emotion_changed}, 8'h00);
        rst = 1'b0;
        idle(1);

        // Wake: undebounced commit
        put(4'd15, 4'd0, 4'd8, 2'b00);
        check_eq("wake_lat1", emotion, 8'h00);
        idle(1);
        check_eq("wake_emotion",  emotion, 8'h04);
        check_eq("wake_pulse",    {7'd0, emotion_changed}, 8'h01);
        check_eq("wake_sleeping", {7'd0, sleeping}, 8'h00);
        idle(1);
        check_eq("wake_pulse_end", {7'd0, emotion_changed}, 8'h00);

        // Debounce with idle gaps between samples
        put(4'd8, 4'd0, 4'd8, 2'b00); idle(2);
        put(4'd8, 4'd0, 4'd8, 2'b00); idle(3);
        put(4'd8, 4'd0, 4'd8, 2'b00); idle(1);
        check_eq("deb3_emotion", emotion, 8'h04);
        check_eq("deb3_pending", {7'd0, pending}, 8'h01);
        check_eq("deb3_nopulse", {7'd0, emotion_changed}, 8'h00);
        put(4'd8, 4'd0, 4'd8, 2'b00); idle(1);
        check_eq("deb4_emotion", emotion, 8'h02);
        check_eq("deb4_pulse",   {7'd0, emotion_changed}, 8'h01);
        check_eq("deb4_pending", {7'd0, pending}, 8'h00);
        idle(1);
        check_eq("deb4_pulse_end", {7'd0, emotion_changed}, 8'h00);

        // Back-to-back samples return to 0x04
        for (int i = 0; i < 4; i++) put(4'd15, 4'd0, 4'd8, 2'b00);
        idle(1);
        check_eq("b2b_emotion", emotion, 8'h04);

        // Glitch rejection
        put(4'd8, 4'd0, 4'd8, 2'b00);
        put(4'd8, 4'd0, 4'd8, 2'b00); idle(1);
        check_eq("gl_pending_hi", {7'd0, pending}, 8'h01);
        put(4'd15, 4'd0, 4'd8, 2'b00); idle(1);
        check_eq("gl_pending_lo", {7'd0, pending}, 8'h00);
        check_eq("gl_emotion",    emotion, 8'h04);
        check_eq("gl_nopulse",    {7'd0, emotion_changed}, 8'h00);

        // Sleep from 0x02
        for (int i = 0; i < 4; i++) put(4'd8, 4'd0, 4'd8, 2'b00);
        idle(1);
        check_eq("pre_sleep_emotion", emotion, 8'h02);
        put(4'd8, 4'd0, 4'd8, 2'b01); idle(1);
        check_eq("sleep_emotion",  emotion, 8'h00);
        check_eq("sleep_sleeping", {7'd0, sleeping}, 8'h01);
        check_eq("sleep_pulse",    {7'd0, emotion_changed}, 8'h01);
        put(4'd8, 4'd0, 4'd8, 2'b10); idle(1);
        check_eq("sleep2_nopulse", {7'd0, emotion_changed}, 8'h00);

        // Threshold boundaries (stress=0, pleasure=0)
        for (int i = 0; i < 4; i++) put(4'd3, 4'd0, 4'd0, 2'b00);
        idle(1);
        check_eq("th_e3", emotion, 8'h10);
        for (int i = 0; i < 4; i++) put(4'd4, 4'd0, 4'd0, 2'b00);
        idle(1);
        check_eq("th_e4", emotion, 8'h08);
        for (int i = 0; i < 4; i++) put(4'd11, 4'd0, 4'd0, 2'b00);
        idle(1);
        check_eq("th_e11", emotion, 8'h08);
        // energy HIGH with stress and pleasure LOW still drives the bit-3 term
        for (int i = 0; i < 4; i++) put(4'd12, 4'd0, 4'd0, 2'b00);
        idle(1);
        check_eq("th_e12",         emotion, 8'h08);
        check_eq("th_e12_pending", {7'd0, pending}, 8'h00);

        // Reset mid-PENDING with a sample sitting in stage 1
        put(4'd3, 4'd0, 4'd0, 2'b00);
        put(4'd3, 4'd0, 4'd0, 2'b00); idle(1);
        check_eq("rp_pending", {7'd0, pending}, 8'h01);
        energy = 4'd15; stress = 4'd0; pleasure = 4'd8; physical_state = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_eq("rp_emotion",  emotion, 8'h00);
        check_eq("rp_sleeping", {7'd0, sleeping}, 8'h01);
        check_eq("rp_pending0", {7'd0, pending}, 8'h00);
        check_eq("rp_changed",  {7'd0, emotion_changed}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        check_eq("rp_discard_emotion",  emotion, 8'h00);
        check_eq("rp_discard_sleeping", {7'd0, sleeping}, 8'h01);
        put(4'd15, 4'd0, 4'd8, 2'b00); idle(1);
        check_eq("rp_wake_emotion", emotion, 8'h04);
        check_eq("rp_wake_pulse",   {7'd0, emotion_changed}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
